// File: rtl/axi4l_clint_if.sv
// axi4l_if: 32-bit AXI4-Lite bundle shared between the interconnect and its slaves
interface axi4l_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_clint.sv
// axi4l_clint: AXI4-Lite core-local interruptor with shared prescaled mtime and per-hart timer/software interrupts
module axi4l_clint #(
  parameter int NUM_HARTS  = 1,
  parameter int PRESCALE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip,
  axi4l_if.slave               axi
);
  localparam logic [9:0] CMP_END  = 10'(4 + 2 * NUM_HARTS);
  localparam logic [9:0] MSIP_END = 10'(64 + NUM_HARTS);
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp [NUM_HARTS];
  logic [31:0]           shadow, wd, r_word, ctrl_word, ctrl_new, w_data_q;
  logic [PRESCALE_W-1:0] div, cnt;
  logic                  en, tick, aw_held, w_held, wr_en, ar_hs;
  logic [9:0]            aw_idx_q, w_idx, r_idx;
  logic [3:0]            w_strb_q, ws;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    merge = o;
    for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = n[8*b +: 8];
  endfunction

  function automatic logic mapped(input logic [9:0] idx);
    return idx < 10'd3 || (idx >= 10'd4 && idx < CMP_END) || (idx >= 10'd64 && idx < MSIP_END);
  endfunction

  assign axi.awready = !aw_held;
  assign axi.wready  = !w_held;
  assign axi.arready = !axi.rvalid || axi.rready;
  assign w_idx     = aw_held ? aw_idx_q : axi.awaddr[11:2];
  assign wd        = w_held ? w_data_q : axi.wdata;
  assign ws        = w_held ? w_strb_q : axi.wstrb;
  assign wr_en     = (aw_held || axi.awvalid) && (w_held || axi.wvalid) && (!axi.bvalid || axi.bready);
  assign ar_hs     = axi.arvalid && axi.arready;
  assign r_idx     = axi.araddr[11:2];
  assign tick      = en && cnt == div;
  assign ctrl_word = 32'({div, 7'b0, en});
  assign ctrl_new  = merge(ctrl_word, wd, ws);

  // MTIMEH reads the shadow captured by the last MTIME read, never live mtime
  always_comb begin
    r_word = '0;
    if (r_idx == 10'd0) r_word = mtime[31:0];
    if (r_idx == 10'd1) r_word = shadow;
    if (r_idx == 10'd2) r_word = ctrl_word;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (r_idx == 10'(4 + 2 * h)) r_word = mtimecmp[h][31:0];
      if (r_idx == 10'(5 + 2 * h)) r_word = mtimecmp[h][63:32];
      if (r_idx == 10'(64 + h)) r_word = {31'b0, msip[h]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime      <= '0;
      shadow     <= '0;
      en         <= 1'b1;
      div        <= '0;
      cnt        <= '0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rresp  <= 2'b00;
      axi.rdata  <= '0;
      mtip       <= '0;
      msip       <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      if (wr_en) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (axi.awvalid && !aw_held) begin
          aw_held  <= 1'b1;
          aw_idx_q <= axi.awaddr[11:2];
        end
        if (axi.wvalid && !w_held) begin
          w_held   <= 1'b1;
          w_data_q <= axi.wdata;
          w_strb_q <= axi.wstrb;
        end
      end
      if (wr_en && w_idx == 10'd2) begin
        en  <= ctrl_new[0];
        div <= ctrl_new[8 +: PRESCALE_W];
        cnt <= '0;
      end else if (en) cnt <= tick ? '0 : PRESCALE_W'(cnt + 1'b1);
      // a software write to mtime suppresses that cycle's increment
      if (wr_en && w_idx == 10'd0) mtime[31:0] <= merge(mtime[31:0], wd, ws);
      else if (wr_en && w_idx == 10'd1) mtime[63:32] <= merge(mtime[63:32], wd, ws);
      else if (tick) mtime <= mtime + 64'd1;
      if (ar_hs) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= r_word;
        axi.rresp  <= mapped(r_idx) ? 2'b00 : 2'b10;
        if (r_idx == 10'd0) shadow <= mtime[63:32];
      end else if (axi.rready) axi.rvalid <= 1'b0;
      if (wr_en) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= mapped(w_idx) ? 2'b00 : 2'b10;
      end else if (axi.bready) axi.bvalid <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_en && w_idx == 10'(4 + 2 * h)) mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wd, ws);
        if (wr_en && w_idx == 10'(5 + 2 * h)) mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wd, ws);
        if (wr_en && w_idx == 10'(64 + h) && ws[0]) msip[h] <= wd[0];
        mtip[h] <= mtime >= mtimecmp[h];
      end
    end
  end
endmodule

// File: tb/tb_axi4l_clint.sv
// tb_axi4l_clint: directed and randomized checks of axi4l_clint against a time-based reference model
module tb_axi4l_clint;
  localparam int NH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NH-1:0] mtip, msip;
  axi4l_if axi ();
  axi4l_clint #(.NUM_HARTS(NH), .PRESCALE_W(8)) dut (.clk(clk), .rst_n(rst_n), .mtip(mtip), .msip(msip), .axi(axi));
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint unsigned edges = 0;
  // model: mtime is base plus the number of prescaler periods elapsed since the base was set
  logic [63:0] m_base;
  longint unsigned m_tb, m_t0;
  logic m_en;
  logic [7:0] m_div;
  logic [63:0] m_cmp [NH];
  logic [NH-1:0] m_msip;
  logic [31:0] m_shadow;

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mt(input longint unsigned e);
    longint unsigned p = longint'(m_div) + 1;
    return m_en ? m_base + ((e - m_t0) / p) - ((m_tb - m_t0) / p) : m_base;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    int idx = int'(a[11:2]);
    return idx inside {[0:2]} || (idx >= 4 && idx < 4 + 2 * NH) || (idx >= 64 && idx < 64 + NH);
  endfunction

  task automatic model_reset();
    m_base = '0; m_tb = edges; m_t0 = edges; m_en = 1'b1; m_div = '0;
    m_msip = '0; m_shadow = '0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
  endtask

  task automatic apply_wr(input longint unsigned e, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[11:2]);
    logic [63:0] v;
    logic [31:0] c;
    if (!mapped(a)) return;
    if (idx < 2) begin
      v = mt(e - 1);
      if (idx == 0) v[31:0] = mrg(v[31:0], d, s);
      else v[63:32] = mrg(v[63:32], d, s);
      m_base = v; m_tb = e;
    end else if (idx == 2) begin
      v = mt(e);
      c = mrg({16'b0, m_div, 7'b0, m_en}, d, s);
      m_base = v; m_tb = e; m_t0 = e; m_en = c[0]; m_div = c[15:8];
    end else if (idx < 64) begin
      if (idx % 2 == 0) m_cmp[(idx-4)/2][31:0] = mrg(m_cmp[(idx-4)/2][31:0], d, s);
      else m_cmp[(idx-4)/2][63:32] = mrg(m_cmp[(idx-4)/2][63:32], d, s);
    end else if (s[0]) m_msip[idx-64] = d[0];
  endtask

  task automatic check_irq();
    for (int h = 0; h < NH; h++) begin
      chk("mtip", mtip[h], mt(edges - 1) >= m_cmp[h]);
      chk("msip", msip[h], m_msip[h]);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int stall);
    logic [1:0] r = mapped(a) ? 2'b00 : 2'b10;
    axi.awaddr = a; axi.awvalid = 1; axi.wdata = d; axi.wstrb = s; axi.wvalid = 1; axi.bready = 0;
    tick();
    apply_wr(edges, a, d, s);
    axi.awvalid = 0; axi.wvalid = 0;
    chk("bvalid", axi.bvalid, 1);
    chk("bresp", axi.bresp, r);
    repeat (stall) begin
      tick();
      chk("bvalid_hold", axi.bvalid, 1);
      chk("bresp_hold", axi.bresp, r);
      chk("awready_free", axi.awready, 1);
    end
    axi.bready = 1;
    tick();
    chk("bvalid_clr", axi.bvalid, 0);
    axi.bready = 0;
    check_irq();
  endtask

  task automatic rd(input logic [31:0] a, input int stall);
    int idx = int'(a[11:2]);
    logic [31:0] exp = '0;
    logic [63:0] v;
    longint unsigned n;
    axi.araddr = a; axi.arvalid = 1; axi.rready = 0;
    tick();
    n = edges;
    axi.arvalid = 0;
    if (idx == 0) begin
      v = mt(n - 1); exp = v[31:0]; m_shadow = v[63:32];
    end else if (idx == 1) exp = m_shadow;
    else if (idx == 2) exp = {16'b0, m_div, 7'b0, m_en};
    else if (mapped(a) && idx < 64) exp = (idx % 2 == 0) ? m_cmp[(idx-4)/2][31:0] : m_cmp[(idx-4)/2][63:32];
    else if (mapped(a)) exp = {31'b0, m_msip[idx-64]};
    chk("rvalid", axi.rvalid, 1);
    chk("rdata", axi.rdata, exp);
    chk("rresp", axi.rresp, mapped(a) ? 2'b00 : 2'b10);
    repeat (stall) begin
      tick();
      chk("rvalid_hold", axi.rvalid, 1);
      chk("rdata_hold", axi.rdata, exp);
    end
    axi.rready = 1;
    tick();
    chk("rvalid_clr", axi.rvalid, 0);
    axi.rready = 0;
    check_irq();
  endtask

  initial begin
    logic [31:0] addrs [14] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                                32'h20, 32'h100, 32'h104, 32'h108, 32'h200, 32'h1000};
    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
    #1;
    repeat (3) tick();
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_bresp", axi.bresp, 0);
    chk("rst_rresp", axi.rresp, 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_awready", axi.awready, 1);
    chk("rst_wready", axi.wready, 1);
    chk("rst_arready", axi.arready, 1);
    chk("rst_mtip", mtip, 0);
    chk("rst_msip", msip, 0);
    rst_n = 1;
    model_reset();
    repeat (18) tick();
    rd(32'h0, 0);
    rd(32'h4, 1);
    rd(32'h14, 0);
    wr(32'h8, 32'h301, 4'hF, 0);
    repeat ($urandom_range(1, 9)) tick();
    rd(32'h0, 0);
    repeat ($urandom_range(4, 12)) tick();
    rd(32'h0, 2);
    rd(32'h8, 0);
    wr(32'h8, 32'h300, 4'hF, 0);
    rd(32'h0, 0);
    repeat (50) tick();
    rd(32'h0, 0);
    wr(32'h8, 32'h1, 4'hF, 0);
    wr(32'h100, 32'hAABBCCDD, 4'b0010, 0);
    chk("msip_unstrobed", msip[0], 0);
    wr(32'h100, 32'h1, 4'b0001, 0);
    chk("msip_set", msip[0], 1);
    wr(32'h0, 32'hFFFF_FFFE, 4'hF, 0);
    wr(32'h4, 32'hFFFF_FFFF, 4'hF, 0);
    repeat (2) tick();
    rd(32'h0, 0);
    rd(32'h4, 0);
    wr(32'h0, 32'h0, 4'hF, 0);
    wr(32'h4, 32'h0, 4'hF, 0);
    wr(32'h18, 32'd100, 4'hF, 0);
    wr(32'h1C, 32'h0, 4'hF, 0);
    for (int k = 0; k < 130; k++) begin
      tick();
      chk("mtip1_cmp", mtip[1], mt(edges - 1) >= m_cmp[1]);
      chk("mtip0_cmp", mtip[0], mt(edges - 1) >= m_cmp[0]);
    end
    wr(32'h18, 32'hFFFF_FFFF, 4'hF, 0);
    chk("mtip1_clear", mtip[1], 0);
    wr(32'hC, 32'h1234, 4'hF, 1);
    rd(32'hC, 0);
    rd(32'h108, 1);
    wr(32'h108, 32'h1, 4'hF, 0);
    rd(32'h20, 0);
    axi.awaddr = 32'h104; axi.awvalid = 1; axi.bready = 0;
    tick();
    axi.awvalid = 0;
    chk("aw_held", axi.awready, 0);
    chk("no_b_yet", axi.bvalid, 0);
    repeat (4) tick();
    axi.wdata = 32'h1; axi.wstrb = 4'h1; axi.wvalid = 1;
    tick();
    apply_wr(edges, 32'h104, 32'h1, 4'h1);
    axi.wvalid = 0;
    chk("late_w_bvalid", axi.bvalid, 1);
    chk("late_w_bresp", axi.bresp, 0);
    chk("late_w_awready", axi.awready, 1);
    axi.awaddr = 32'hC; axi.awvalid = 1; axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wvalid = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0;
    repeat (2) begin
      chk("stall_awready", axi.awready, 0);
      chk("stall_wready", axi.wready, 0);
      chk("stall_bvalid", axi.bvalid, 1);
      chk("stall_bresp", axi.bresp, 0);
      tick();
    end
    axi.bready = 1;
    tick();
    apply_wr(edges, 32'hC, 32'h5, 4'hF);
    chk("second_bvalid", axi.bvalid, 1);
    chk("second_bresp", axi.bresp, 2'b10);
    tick();
    chk("second_bclr", axi.bvalid, 0);
    axi.bready = 0;
    check_irq();
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a = addrs[$urandom_range(0, 13)];
      if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else rd(a, $urandom_range(0, 3));
    end
    axi.awaddr = 32'h100; axi.awvalid = 1; axi.bready = 0;
    tick();
    axi.awvalid = 0;
    rst_n = 0;
    tick();
    chk("mid_rst_awready", axi.awready, 1);
    chk("mid_rst_bvalid", axi.bvalid, 0);
    chk("mid_rst_msip", msip, 0);
    chk("mid_rst_mtip", mtip, 0);
    rst_n = 1;
    model_reset();
    axi.wdata = 32'h1; axi.wstrb = 4'h1; axi.wvalid = 1;
    tick();
    axi.wvalid = 0;
    chk("aw_discarded", axi.bvalid, 0);
    chk("w_held_after_rst", axi.wready, 0);
    axi.awaddr = 32'h100; axi.awvalid = 1; axi.bready = 1;
    tick();
    apply_wr(edges, 32'h100, 32'h1, 4'h1);
    axi.awvalid = 0;
    chk("post_rst_bvalid", axi.bvalid, 1);
    chk("post_rst_bresp", axi.bresp, 0);
    tick();
    axi.bready = 0;
    check_irq();
    rd(32'h0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
